// File: rtl/mem_io_pkg.sv
// Shared types and constants for the SLC-3 memory/IO responder.
package mem_io_pkg;

   localparam int unsigned WAIT_W          = 4;
   localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_WR_WAIT,
      ST_DONE,
      ST_RELEASE
   } mem_io_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (board switches).
module sync_2ff #(
   parameter int unsigned N = 10
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] q_o
);

   logic [N-1:0] meta_q;
   logic [N-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/mem_io_responder.sv
// CPU-bus responder: runs each MEM_OE/MEM_WE request as a timed async-SRAM cycle
// or a memory-mapped I/O access, and returns a one-cycle ready pulse R.
module mem_io_responder
   import mem_io_pkg::*;
#(
   parameter int unsigned READ_WAIT  = 2,
   parameter int unsigned WRITE_WAIT = 2,
   parameter logic [15:0] IO_ADDR    = IO_ADDR_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MEM_OE,
   input  logic        MEM_WE,
   input  logic [15:0] ADDR,
   input  logic [15:0] Data_from_CPU,
   output logic [15:0] Data_to_CPU,
   output logic        R,
   input  logic [9:0]  Switches,
   output logic [15:0] HEX,
   output logic [15:0] SRAM_ADDR,
   output logic [15:0] SRAM_DQ_OUT,
   input  logic [15:0] SRAM_DQ_IN,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N
);

   mem_io_state_t     state_q;
   logic [WAIT_W-1:0] cnt_q;
   logic [15:0]       rdata_q;
   logic [15:0]       hex_q;
   logic [15:0]       addr_q;
   logic [15:0]       dq_out_q;
   logic              r_q;
   logic              ce_n_q;
   logic              oe_n_q;
   logic              we_n_q;
   logic [9:0]        sw_sync;
   logic              req_idle;

   sync_2ff #(
      .N (10)
   ) u_sw_sync (
      .clk_i  (Clk),
      .rst_ni (Reset),
      .d_i    (Switches),
      .q_o    (sw_sync)
   );

   assign req_idle = !MEM_OE && !MEM_WE;

   // Strobes are set on the same edge that enters/leaves a wait state, so they stay registered.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         rdata_q  <= '0;
         hex_q    <= '0;
         addr_q   <= '0;
         dq_out_q <= '0;
         r_q      <= 1'b0;
         ce_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (MEM_WE) begin
                  addr_q   <= ADDR;
                  dq_out_q <= Data_from_CPU;
                  if (ADDR == IO_ADDR) begin
                     hex_q   <= Data_from_CPU;
                     r_q     <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     ce_n_q  <= 1'b0;
                     we_n_q  <= 1'b0;
                     cnt_q   <= WAIT_W'(WRITE_WAIT);
                     state_q <= ST_WR_WAIT;
                  end
               end else if (MEM_OE) begin
                  addr_q <= ADDR;
                  if (ADDR == IO_ADDR) begin
                     rdata_q <= {6'b0, sw_sync};
                     r_q     <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     ce_n_q  <= 1'b0;
                     oe_n_q  <= 1'b0;
                     cnt_q   <= WAIT_W'(READ_WAIT);
                     state_q <= ST_RD_WAIT;
                  end
               end
            end
            ST_RD_WAIT: begin
               if (cnt_q == WAIT_W'(1)) begin
                  rdata_q <= SRAM_DQ_IN;
                  ce_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  r_q     <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_WR_WAIT: begin
               if (cnt_q == WAIT_W'(1)) begin
                  ce_n_q  <= 1'b1;
                  we_n_q  <= 1'b1;
                  r_q     <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_DONE: begin
               r_q     <= 1'b0;
               state_q <= req_idle ? ST_IDLE : ST_RELEASE;
            end
            ST_RELEASE: begin
               if (req_idle) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               r_q     <= 1'b0;
               ce_n_q  <= 1'b1;
               oe_n_q  <= 1'b1;
               we_n_q  <= 1'b1;
            end
         endcase
      end
   end

   assign Data_to_CPU = rdata_q;
   assign R           = r_q;
   assign HEX         = hex_q;
   assign SRAM_ADDR   = addr_q;
   assign SRAM_DQ_OUT = dq_out_q;
   assign SRAM_CE_N   = ce_n_q;
   assign SRAM_OE_N   = oe_n_q;
   assign SRAM_WE_N   = we_n_q;

endmodule
